// File: rtl/clock_pkg.sv
// clock_pkg: shared limits, reset values and days-in-month helper for the clock calendar
package clock_pkg;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [3:0] MONTH_MAX = 4'd12;
  localparam logic [4:0] RST_HOUR = 5'd0;
  localparam logic [4:0] RST_DATE = 5'd1;
  localparam logic [3:0] RST_MONTH = 4'd1;
  localparam logic [7:0] RST_YEAR = 8'd0;
  localparam logic [1:0] RST_CONTROL = 2'd0;
  // Leap rule year[1:0]==0 is exact over 2000..2099
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [7:0] year);
    return month == 4'd2 ? (year[1:0] == 2'd0 ? 5'd29 : 5'd28) :
           (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? 5'd30 : 5'd31;
  endfunction
endpackage

// File: rtl/bcd_mod60.sv
// bcd_mod60: two-digit BCD counter 00..TENS_MAX9 with sync clear
// Ports: clk, rst_n (sync active-low), clr (sync clear to 00), inc (step),
//        ones/tens (BCD digits), carry (inc while at the top value, combinational)
module bcd_mod60 #(
  parameter logic [3:0] TENS_MAX = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry
);
  logic [3:0] r_ones, r_tens;
  assign ones = r_ones;
  assign tens = r_tens;
  assign carry = inc && r_ones == 4'd9 && r_tens == TENS_MAX;
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else if (inc) begin
      r_ones <= r_ones == 4'd9 ? 4'd0 : r_ones + 4'd1;
      r_tens <= r_ones != 4'd9 ? r_tens : r_tens == TENS_MAX ? 4'd0 : r_tens + 4'd1;
    end
endmodule

// File: rtl/clock_calendar_counter.sv
// clock_calendar_counter: seconds-to-years clock/calendar with set pulses and digit-scan select
// Ports: clk, rst_n (sync active-low), tick_1hz (run step), scan_tick (scan step),
//        set_min/set_hour/set_date/set_month/set_year (field increments, tick dropped),
//        sec1/sec2/min1/min2 (BCD), hour/date/month/year (binary), control (scan 0..3)
module clock_calendar_counter
  import clock_pkg::*;
#(
  parameter int YEAR_MAX = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       scan_tick,
  input  logic       set_min,
  input  logic       set_hour,
  input  logic       set_date,
  input  logic       set_month,
  input  logic       set_year,
  output logic [3:0] sec1,
  output logic [3:0] sec2,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic [4:0] hour,
  output logic [4:0] date,
  output logic [3:0] month,
  output logic [7:0] year,
  output logic [1:0] control
);
  logic [4:0] r_hour, r_date;
  logic [3:0] r_month;
  logic [7:0] r_year;
  logic [1:0] r_control;
  logic w_run, w_sec_c, w_min_c, w_hour_c, w_date_c, w_month_c;
  logic [4:0] w_hour_nx, w_dim_cur, w_dim_nx, w_date_step, w_date_nx;
  logic [3:0] w_month_nx;
  logic [7:0] w_year_nx;
  // Any set pulse swallows the 1 Hz tick, so carries only propagate in run mode
  assign w_run = tick_1hz && !(set_min || set_hour || set_date || set_month || set_year);
  bcd_mod60 #(.TENS_MAX(SEC_TENS_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(set_min || set_hour), .inc(w_run),
    .ones(sec1), .tens(sec2), .carry(w_sec_c)
  );
  bcd_mod60 #(.TENS_MAX(MIN_TENS_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(set_min || w_sec_c),
    .ones(min1), .tens(min2), .carry(w_min_c)
  );
  always_comb begin
    w_hour_c = w_run && w_min_c && r_hour == HOUR_MAX;
    w_hour_nx = (set_hour || (w_run && w_min_c)) ? (r_hour == HOUR_MAX ? 5'd0 : r_hour + 5'd1) : r_hour;
    w_dim_cur = days_in_month(r_month, r_year);
    w_date_c = w_hour_c && r_date >= w_dim_cur;
    w_date_step = (set_date || w_hour_c) ? (r_date >= w_dim_cur ? 5'd1 : r_date + 5'd1) : r_date;
    w_month_c = w_date_c && r_month == MONTH_MAX;
    w_month_nx = (set_month || w_date_c) ? (r_month == MONTH_MAX ? 4'd1 : r_month + 4'd1) : r_month;
    w_year_nx = (set_year || w_month_c) ? (r_year >= 8'(YEAR_MAX) ? 8'd0 : r_year + 8'd1) : r_year;
    // Clamp against the month/year being written this cycle, not the current ones
    w_dim_nx = days_in_month(w_month_nx, w_year_nx);
    w_date_nx = w_date_step > w_dim_nx ? w_dim_nx : w_date_step;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_hour <= RST_HOUR;
      r_date <= RST_DATE;
      r_month <= RST_MONTH;
      r_year <= RST_YEAR;
      r_control <= RST_CONTROL;
    end else begin
      r_hour <= w_hour_nx;
      r_date <= w_date_nx;
      r_month <= w_month_nx;
      r_year <= w_year_nx;
      r_control <= scan_tick ? r_control + 2'd1 : r_control;
    end
  assign hour = r_hour;
  assign date = r_date;
  assign month = r_month;
  assign year = r_year;
  assign control = r_control;
endmodule

// File: tb/tb_clock_calendar_counter.sv
// tb_clock_calendar_counter: directed self-checking bench for clock_calendar_counter
module tb_clock_calendar_counter;
  localparam int B_MIN = 1, B_HOUR = 2, B_DATE = 4, B_MONTH = 8, B_YEAR = 16, B_TICK = 32, B_SCAN = 64;
  logic clk = 0, rst_n = 0, tick_1hz = 0, scan_tick = 0;
  logic set_min = 0, set_hour = 0, set_date = 0, set_month = 0, set_year = 0;
  logic [3:0] sec1, sec2, min1, min2, month;
  logic [4:0] hour, date;
  logic [7:0] year;
  logic [1:0] control;
  logic [37:0] all;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  clock_calendar_counter #(.YEAR_MAX(99)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .scan_tick(scan_tick),
    .set_min(set_min), .set_hour(set_hour), .set_date(set_date), .set_month(set_month), .set_year(set_year),
    .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2),
    .hour(hour), .date(date), .month(month), .year(year), .control(control)
  );
  assign all = {year, month, date, hour, min2, min1, sec2, sec1};
  function automatic logic [37:0] pk(input int y, mo, d, h, m, s);
    return {8'(y), 4'(mo), 5'(d), 5'(h), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  task automatic pulse(input int m);
    {scan_tick, tick_1hz, set_year, set_month, set_date, set_hour, set_min} = 7'(m);
    @(negedge clk);
    {scan_tick, tick_1hz, set_year, set_month, set_date, set_hour, set_min} = 7'd0;
  endtask
  task automatic do_reset;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic preset(input int y, mo, d, h, mi, s);
    do_reset();
    repeat (y) pulse(B_YEAR);
    repeat (mo - 1) pulse(B_MONTH);
    repeat (d - 1) pulse(B_DATE);
    repeat (h) pulse(B_HOUR);
    repeat (mi) pulse(B_MIN);
    repeat (s) pulse(B_TICK);
  endtask
  task automatic test_reset;
    rst_n = 0;
    tick_1hz = 1;
    repeat (2) @(negedge clk);
    total++;
    if (all !== pk(0, 1, 1, 0, 0, 0)) begin bad++; $display("FAIL reset_fields got=%h exp=%h", all, pk(0, 1, 1, 0, 0, 0)); end
    total++;
    if (control !== 2'd0) begin bad++; $display("FAIL reset_control got=%0d exp=0", control); end
    tick_1hz = 0;
    rst_n = 1;
  endtask
  task automatic test_rollover;
    preset(99, 12, 31, 23, 59, 59);
    total++;
    if (all !== pk(99, 12, 31, 23, 59, 59)) begin bad++; $display("FAIL preset_max got=%h exp=%h", all, pk(99, 12, 31, 23, 59, 59)); end
    pulse(B_TICK);
    total++;
    if (all !== pk(0, 1, 1, 0, 0, 0)) begin bad++; $display("FAIL full_rollover got=%h exp=%h", all, pk(0, 1, 1, 0, 0, 0)); end
    preset(99, 12, 31, 23, 59, 59);
    rst_n = 0;
    pulse(B_TICK);
    rst_n = 1;
    total++;
    if (all !== pk(0, 1, 1, 0, 0, 0)) begin bad++; $display("FAIL reset_mid_carry got=%h exp=%h", all, pk(0, 1, 1, 0, 0, 0)); end
  endtask
  task automatic test_leap;
    preset(24, 2, 28, 23, 59, 59);
    pulse(B_TICK);
    total++;
    if (all !== pk(24, 2, 29, 0, 0, 0)) begin bad++; $display("FAIL leap_feb got=%h exp=%h", all, pk(24, 2, 29, 0, 0, 0)); end
    preset(23, 2, 28, 23, 59, 59);
    pulse(B_TICK);
    total++;
    if (all !== pk(23, 3, 1, 0, 0, 0)) begin bad++; $display("FAIL nonleap_feb got=%h exp=%h", all, pk(23, 3, 1, 0, 0, 0)); end
  endtask
  task automatic test_clamp;
    preset(0, 3, 31, 0, 0, 0);
    pulse(B_MONTH);
    total++;
    if (all !== pk(0, 4, 30, 0, 0, 0)) begin bad++; $display("FAIL clamp_month got=%h exp=%h", all, pk(0, 4, 30, 0, 0, 0)); end
    preset(24, 2, 29, 0, 0, 0);
    pulse(B_YEAR);
    total++;
    if (all !== pk(25, 2, 28, 0, 0, 0)) begin bad++; $display("FAIL clamp_year got=%h exp=%h", all, pk(25, 2, 28, 0, 0, 0)); end
    preset(0, 1, 31, 0, 0, 0);
    pulse(B_DATE);
    total++;
    if (all !== pk(0, 1, 1, 0, 0, 0)) begin bad++; $display("FAIL date_wrap_no_carry got=%h exp=%h", all, pk(0, 1, 1, 0, 0, 0)); end
  endtask
  task automatic test_set_vs_tick;
    preset(0, 1, 1, 10, 15, 42);
    pulse(B_HOUR | B_TICK);
    total++;
    if (all !== pk(0, 1, 1, 11, 15, 0)) begin bad++; $display("FAIL set_hour_tick got=%h exp=%h", all, pk(0, 1, 1, 11, 15, 0)); end
    preset(0, 1, 1, 10, 59, 30);
    pulse(B_MIN);
    total++;
    if (all !== pk(0, 1, 1, 10, 0, 0)) begin bad++; $display("FAIL set_min_wrap got=%h exp=%h", all, pk(0, 1, 1, 10, 0, 0)); end
    preset(0, 1, 1, 23, 0, 0);
    set_hour = 1;
    repeat (3) @(negedge clk);
    set_hour = 0;
    total++;
    if (all !== pk(0, 1, 1, 2, 0, 0)) begin bad++; $display("FAIL held_set_hour got=%h exp=%h", all, pk(0, 1, 1, 2, 0, 0)); end
  endtask
  task automatic test_scan;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      pulse(B_SCAN);
      total++;
      if (control !== 2'(i % 4)) begin bad++; $display("FAIL scan_%0d got=%0d exp=%0d", i, control, i % 4); end
    end
    pulse(B_TICK);
    total++;
    if (control !== 2'd2) begin bad++; $display("FAIL scan_hold got=%0d exp=2", control); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_rollover();
    test_leap();
    test_clamp();
    test_set_vs_tick();
    test_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_calendar_counter.md
# clock_calendar_counter

Time-of-day and calendar counter for the electronic clock. It advances seconds through years on a one-cycle 1 Hz enable and accepts per-field increment pulses for setting the time. It also generates the 2-bit digit-scan select. Its outputs drive the field and `control` inputs of the seven-segment scan/display block directly: minutes and seconds as BCD digit pairs, hour/date/month/year as binary.

## Interface
Parameters:
- `YEAR_MAX`, 99: last year value (years 0..`YEAR_MAX` map to 2000..2000+`YEAR_MAX`); wraps to 0.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: synchronous to `clk`, active-low.
- `tick_1hz`  in  1  one-cycle pulse, once per second.
- `scan_tick`  in  1  one-cycle pulse at the digit refresh rate.
- `set_min`, `set_hour`, `set_date`, `set_month`, `set_year`  in  1 each  one-cycle increment pulses (already debounced and one-pulsed).
- `sec1`, `sec2`  out  4 each  seconds ones / tens, BCD.
- `min1`, `min2`  out  4 each  minutes ones / tens, BCD.
- `hour`  out  5  0..23, binary.
- `date`  out  5  1..31, binary.
- `month`  out  4  1..12, binary.
- `year`  out  8  0..`YEAR_MAX`, binary.
- `control`  out  2  digit-scan select, 0..3.

## Operation
- All state is in registers and all outputs come straight from them. Every update happens on a rising `clk`.
- Reset (`rst_n`=0 at an edge) loads these values: `sec1`=`sec2`=`min1`=`min2`=0, `hour`=0, `date`=1, `month`=1, `year`=0, `control`=0. Reset overrides every other input.
- Run mode, on a `tick_1hz` cycle with no set pulse active:
  - `sec1` counts 0..9. Its wrap carries into `sec2` (0..5).
  - The `sec2` wrap carries into `min1` (0..9), which carries into `min2` (0..5).
  - The `min2` wrap carries into `hour` (0..23).
  - The `hour` wrap carries into `date` (1..dim). The `date` wrap carries into `month` (1..12). The `month` wrap carries into `year` (0..`YEAR_MAX`, then 0).
  - The whole carry chain resolves in that single cycle.
- Days in month (dim):
  - 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for months 4, 6, 9, 11.
  - February: 29 when `year[1:0]`==0, else 28. This rule is exact for 2000..2099.
- Set mode: any `set_*` pulse active in a cycle:
  - Each asserted field increments by 1 and wraps inside its own range. Nothing carries to other fields.
  - `set_min` steps the BCD pair 00..59 as a unit. `set_hour` runs 23→0; `set_date` runs dim→1; `set_month` runs 12→1; `set_year` runs `YEAR_MAX`→0.
  - Seconds clear to 00 on `set_min` or `set_hour`.
  - A `tick_1hz` in the same cycle is dropped. Multiple set pulses in one cycle all apply.
- Date clamp: whenever the next month/year gives a dim below the next `date`, `date` takes that dim in the same cycle. Examples: Mar 31 + `set_month` → Apr 30; Feb 29 + `set_year` into a non-leap year → Feb 28.
- Scan: `control` increments mod 4 on each `scan_tick`, independent of the time and set logic.

## Timing
- Latency: every output reflects a tick or set pulse on the edge after the pulse is sampled (1 cycle). There is no multi-cycle carry.
- Pulses are sampled per cycle. A pulse held high for N cycles acts as N events. The block does not edge-detect.
- Reset mid-carry (for example on the rollover edge) leaves exactly the reset values. No partial carry survives.
- Illegal states cannot occur: all writes are range-checked.

## Structure
- Shared package `clock_pkg`:
  - Limits: `SEC_TENS_MAX`=5, `MIN_TENS_MAX`=5, `HOUR_MAX`=23, `MONTH_MAX`=12.
  - Reset constants.
  - Function `days_in_month(month, year)` returning 5 bits.
- One sub-module, `bcd_mod60`: a 2-digit BCD 00..59 counter with `inc` in and `carry` out. It is instantiated twice, for seconds and for minutes; the minutes instance also serves `set_min`.
- The rest (hour/date/month/year chain, clamp, scan counter) stays in the top module.

## Test plan
- Reset: hold `rst_n`=0 with `tick_1hz`=1 → all outputs at reset values, `date`=1, `month`=1.
- Full rollover: preset via set pulses to year 99, 12/31 23:59:59; one `tick_1hz` → year 0, month 1, date 1, hour 0, all BCD digits 0, one cycle later.
- Leap February: year 24, 02/28 23:59:59 + tick → 02/29. Year 23, same time + tick → 03/01.
- Clamp: 03/31 + `set_month` → 04/30. Year 24 02/29 + `set_year` → year 25, 02/28.
- Set vs tick: `set_hour` and `tick_1hz` together at 10:15:42 → 11:15:00. `set_min` at 10:59:30 → 10:00:00, with no hour carry.
- Scan: 6 `scan_tick` pulses from reset → `control` sequence 1, 2, 3, 0, 1, 2. A tick between pulses leaves `control` unchanged.
